// File: rtl/word_hash_pkg.sv
// word_hash_pkg: shared hash constants, sizes and FSM states for the Bloom filter insert and lookup sides
package word_hash_pkg;
    localparam int N_HASH    = 4;
    localparam int LETTER_W  = 5;
    localparam int N_LETTERS = 5;
    localparam int HASH_W    = 12;
    localparam int ROW_W     = 64;
    localparam int N_ROWS    = 64;
    localparam int CNT_W     = 13;
    localparam logic [HASH_W-1:0] HASH_P [0:N_HASH-1][0:N_LETTERS-1] = '{
        '{12'h dcb, 12'h 5bc, 12'h adf, 12'h dd2, 12'h 21c},
        '{12'h 869, 12'h 37a, 12'h 8b5, 12'h 566, 12'h a69},
        '{12'h 613, 12'h 641, 12'h fc8, 12'h d28, 12'h 4cf},
        '{12'h c66, 12'h 602, 12'h 25c, 12'h 387, 12'h a6f}
    };
    typedef enum logic [1:0] {CLEAR, IDLE, RD, WR} state_t;
endpackage

// File: rtl/bloom_insert_if.sv
// bloom_insert_if: insert/clear handshake, status and row-read port of the Bloom filter write side
interface bloom_insert_if;
    import word_hash_pkg::*;
    logic                 clear;
    logic                 ins_valid;
    logic [24:0]          ins_word;
    logic                 ins_ready;
    logic                 done;
    logic                 dup;
    logic [CNT_W-1:0]     fill_count;
    logic [5:0]           rd_addr;
    logic [ROW_W-1:0]     rd_data;
    modport master (
        output clear, ins_valid, ins_word, rd_addr,
        input  ins_ready, done, dup, fill_count, rd_data
    );
    modport slave (
        input  clear, ins_valid, ins_word, rd_addr,
        output ins_ready, done, dup, fill_count, rd_data
    );
endinterface

// File: rtl/word_hash.sv
// word_hash: multiplicative hash k of a 5-letter word, every product and the sum kept mod 4096
module word_hash
    import word_hash_pkg::*;
(
    input  logic [24:0]       word,
    input  logic [1:0]        k,
    output logic [HASH_W-1:0] h
);
    // accumulate the per-letter products; 12-bit arithmetic gives the mod-4096 wrap for free
    always_comb begin
        h = '0;
        for (int j = 0; j < N_LETTERS; j++)
            h = h + HASH_P[k][j] * {7'd0, word[LETTER_W*j +: LETTER_W]};
    end
endmodule

// File: rtl/bloom_insert.sv
// bloom_insert: Bloom filter write side - clear sweep, 4-hash read-modify-write insert, fill count, row read port
module bloom_insert
    import word_hash_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    bloom_insert_if.slave bus
);
    state_t              r_state;
    logic [5:0]          r_cnt;
    logic [24:0]         r_word;
    logic [1:0]          r_k;
    logic                r_dup_acc;
    logic                r_done;
    logic                r_dup;
    logic [ROW_W-1:0]    r_hold;
    logic [ROW_W-1:0]    r_rd_data;
    logic [CNT_W-1:0]    r_fill;
    logic [ROW_W-1:0]    r_mem [0:N_ROWS-1];
    logic [HASH_W-1:0]   w_h;
    logic                w_hit;

    word_hash u_hash (.word(r_word), .k(r_k), .h(w_h));

    assign w_hit          = r_hold[w_h[5:0]];
    assign bus.ins_ready  = (r_state == IDLE) && !bus.clear;
    assign bus.done       = r_done;
    assign bus.dup        = r_dup;
    assign bus.fill_count = r_fill;
    assign bus.rd_data    = r_rd_data;

    // control FSM: clear sweep, accept, then four read/write pairs with done/dup on the final write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= CLEAR;
            r_cnt     <= '0;
            r_fill    <= '0;
            r_word    <= '0;
            r_k       <= '0;
            r_dup_acc <= 1'b0;
            r_hold    <= '0;
            r_done    <= 1'b0;
            r_dup     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                CLEAR: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd63) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                        r_dup   <= 1'b0;
                    end
                end
                IDLE: begin
                    if (bus.clear) begin
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                        r_fill  <= '0;
                    end else if (bus.ins_valid) begin
                        r_word    <= bus.ins_word;
                        r_k       <= '0;
                        r_dup_acc <= 1'b1;
                        r_state   <= RD;
                    end
                end
                RD: begin
                    r_hold  <= r_mem[w_h[11:6]];
                    r_state <= WR;
                end
                WR: begin
                    if (!w_hit)
                        r_fill <= r_fill + 1'b1;
                    r_dup_acc <= r_dup_acc & w_hit;
                    if (r_k == 2'd3) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                        r_dup   <= r_dup_acc & w_hit;
                    end else begin
                        r_k     <= r_k + 2'd1;
                        r_state <= RD;
                    end
                end
            endcase
        end
    end

    // array write port: zero one row per sweep cycle, or write back the held row with the hashed bit set
    always_ff @(posedge clk) begin
        if (r_state == CLEAR)
            r_mem[r_cnt] <= '0;
        else if (r_state == WR)
            r_mem[w_h[11:6]] <= r_hold | (64'd1 << w_h[5:0]);
    end

    // external read port: registered, sees the array contents from before this cycle's write
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rd_data <= '0;
        else
            r_rd_data <= r_mem[bus.rd_addr];
    end
endmodule

// File: tb/tb_bloom_insert.sv
// tb_bloom_insert: directed scoreboard bench for the Bloom filter write side
module tb_bloom_insert;
    typedef struct {
        logic        dup;
        logic [12:0] fill;
    } exp_t;

    localparam int P_TBL [4][5] = '{
        '{'h0dcb, 'h05bc, 'h0adf, 'h0dd2, 'h021c},
        '{'h0869, 'h037a, 'h08b5, 'h0566, 'h0a69},
        '{'h0613, 'h0641, 'h0fc8, 'h0d28, 'h04cf},
        '{'h0c66, 'h0602, 'h025c, 'h0387, 'h0a6f}
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_vec = 0;
    int          n_err = 0;
    exp_t        q[$];
    logic [63:0] model_mem [64];
    int          model_fill = 0;

    bloom_insert_if bus();
    bloom_insert dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [11:0] model_hash(input int k, input logic [24:0] w);
        int s = 0;
        for (int j = 0; j < 5; j++)
            s += P_TBL[k][j] * int'(w[5*j +: 5]);
        return 12'(s % 4096);
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 64; r++)
            model_mem[r] = '0;
        model_fill = 0;
    endtask

    task automatic read_row(input int a, output logic [63:0] d);
        bus.rd_addr = 6'(a);
        @(negedge clk);
        d = bus.rd_data;
    endtask

    task automatic sweep();
        int cnt = 0;
        rst = 1'b0;
        while (!bus.ins_ready && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check("sweep_len", 64'(cnt), 64);
        check("sweep_done", bus.done, 1);
        check("sweep_dup", bus.dup, 0);
        check("sweep_fill", bus.fill_count, 0);
        @(negedge clk);
        check("done_pulse_end", bus.done, 0);
        model_clear();
    endtask

    task automatic do_insert(input logic [24:0] w);
        exp_t e;
        int lat;
        logic [11:0] h;
        e.dup = 1'b1;
        for (int k = 0; k < 4; k++) begin
            h = model_hash(k, w);
            if (!model_mem[h[11:6]][h[5:0]]) begin
                e.dup = 1'b0;
                model_fill++;
                model_mem[h[11:6]][h[5:0]] = 1'b1;
            end
        end
        e.fill = 13'(model_fill);
        q.push_back(e);
        check("ready_before_ins", bus.ins_ready, 1);
        bus.ins_valid = 1'b1;
        bus.ins_word  = w;
        @(negedge clk);
        bus.ins_valid = 1'b0;
        bus.ins_word  = 25'($urandom);
        check("busy_after_accept", bus.ins_ready, 0);
        lat = 1;
        while (!bus.done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("ins_latency", 64'(lat), 9);
        check("ready_with_done", bus.ins_ready, 1);
        if (q.size() > 0) begin
            e = q.pop_front();
            check("ins_dup", bus.dup, e.dup);
            check("ins_fill", bus.fill_count, e.fill);
        end
    endtask

    initial begin
        logic [63:0] d;
        int lat;
        logic [24:0] words [6];
        bus.clear     = 1'b0;
        bus.ins_valid = 1'b0;
        bus.ins_word  = '0;
        bus.rd_addr   = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.ins_ready, 0);
        check("rst_done", bus.done, 0);
        check("rst_dup", bus.dup, 0);
        check("rst_fill", bus.fill_count, 0);
        check("rst_rd_data", bus.rd_data, 0);
        sweep();
        for (int r = 0; r < 64; r++) begin
            read_row(r, d);
            check("post_clear_row", d, 0);
        end

        do_insert(25'h0000001);
        read_row('h37, d);
        check("row37", d, 64'd1 << 'h0b);
        read_row('h21, d);
        check("row21", d, 64'd1 << 'h29);
        read_row('h18, d);
        check("row18", d, 64'd1 << 'h13);
        read_row('h31, d);
        check("row31", d, 64'd1 << 'h26);

        do_insert(25'h0000001);
        check("reins_dup_const", bus.dup, 1);
        read_row('h37, d);
        check("reins_row37", d, 64'd1 << 'h0b);

        bus.clear     = 1'b1;
        bus.ins_valid = 1'b1;
        bus.ins_word  = 25'h0000000;
        #1;
        check("clear_blocks_ready", bus.ins_ready, 0);
        @(negedge clk);
        bus.clear = 1'b0;
        check("clear_not_ready", bus.ins_ready, 0);
        check("clear_fill_zero", bus.fill_count, 0);
        lat = 1;
        while (!bus.done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("clear_len", 64'(lat), 65);
        check("clear_dup", bus.dup, 0);
        check("clear_fill", bus.fill_count, 0);
        model_clear();
        do_insert(25'h0000000);
        read_row(0, d);
        check("zero_word_row0", d, 64'h1);
        read_row('h37, d);
        check("cleared_row37", d, 0);

        for (int i = 0; i < 6; i++) begin
            words[i] = 25'($urandom);
            do_insert(words[i]);
        end
        do_insert(words[2]);
        check("rand_reins_dup", bus.dup, 1);
        for (int r = 0; r < 64; r++) begin
            read_row(r, d);
            check("model_row", d, model_mem[r]);
        end

        bus.ins_valid = 1'b1;
        bus.ins_word  = 25'h0000001;
        @(negedge clk);
        bus.ins_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_ready", bus.ins_ready, 0);
        check("abort_done", bus.done, 0);
        check("abort_dup", bus.dup, 0);
        check("abort_fill", bus.fill_count, 0);
        check("abort_rd_data", bus.rd_data, 0);
        @(negedge clk);
        sweep();
        read_row('h37, d);
        check("abort_row37", d, 0);
        check("queue_empty", 64'(q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
